quad_encoder_emitter: RTL and testbench

- Transmit side of the rotary-encoder input path: turns step requests (direction plus valid/ready handshake) into a two-line quadrature waveform (enc_a, enc_b).
- Can inject contact chatter on the switching line using an LFSR.
- Used as an on-chip self-test source and as the bench stimulus driving the button/encoder debounce and decode chain, so it must reproduce what a real mechanical encoder produces.

---
 rtl/quad_encoder_emitter.sv | 79 +++++++
 tb/tb_quad_encoder_emitter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emitter.sv
// Quadrature encoder emitter: turns step requests into an (enc_a, enc_b) Gray
// sequence, optionally with LFSR-driven contact chatter on the switching line.
module quad_encoder_emitter #(
    parameter int          PHASE_CYCLES  = 16,
    parameter int          BOUNCE_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_valid,
    input  logic       step_dir,
    output logic       step_ready,
    input  logic       bounce_en,
    output logic       enc_a,
    output logic       enc_b,
    output logic       busy,
    output logic [7:0] position
);
    localparam logic [7:0] SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);
    // Chatter applies while the HOLD cycle being produced is below BOUNCE_CYCLES,
    // i.e. while the counter is still above this threshold.
    localparam int         CHAT_THRESH = PHASE_CYCLES - BOUNCE_CYCLES;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] lfsr;
    logic [1:0] quad;
    logic [1:0] quad_old;
    logic       bounce_l;
    logic [1:0] quad_next;
    logic       lfsr_fb;

    // Gray step: cw 00->10->11->01, ccw 00->01->11->10
    assign quad_next = step_dir ? {~quad[0], quad[1]} : {quad[0], ~quad[1]};
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    assign step_ready = (state == IDLE);
    assign busy       = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            lfsr     <= SEED;
            quad     <= 2'b00;
            quad_old <= 2'b00;
            bounce_l <= 1'b0;
            enc_a    <= 1'b0;
            enc_b    <= 1'b0;
            position <= 8'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            case (state)
                IDLE: begin
                    if (step_valid) begin
                        quad_old <= quad;
                        quad     <= quad_next;
                        bounce_l <= bounce_en;
                        cnt      <= PHASE_LAST;
                        position <= step_dir ? position + 8'd1 : position - 8'd1;
                        state    <= HOLD;
                        {enc_a, enc_b} <= (bounce_en && (BOUNCE_CYCLES > 0) && !lfsr[0])
                                          ? quad : quad_next;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) state <= IDLE;
                    else             cnt   <= cnt - 8'd1;
                    {enc_a, enc_b} <= (bounce_l && (int'(cnt) > CHAT_THRESH) && !lfsr[0])
                                      ? quad_old : quad;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_encoder_emitter.sv
// Bench for quad_encoder_emitter: directed scenarios plus random traffic, checked
// every cycle against a step-count based reference model.
module tb_quad_encoder_emitter;
    localparam int P = 16;
    localparam int B = 4;

    logic       clk = 1'b0;
    logic       reset, step_valid, step_dir, bounce_en;
    logic       step_ready, enc_a, enc_b, busy;
    logic [7:0] position;

    quad_encoder_emitter #(.PHASE_CYCLES(P), .BOUNCE_CYCLES(B), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
        .step_ready(step_ready), .bounce_en(bounce_en), .enc_a(enc_a), .enc_b(enc_b),
        .busy(busy), .position(position)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: net step count selects the Gray code; hk is the HOLD cycle index (-1 = idle)
    logic [1:0] tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int         steps = 0;
    int         hk = -1;
    logic [7:0] ml = 8'hA5;
    logic [1:0] m_out = 2'b00, m_old = 2'b00, m_new = 2'b00;
    logic       m_bl = 1'b0;

    // Behavioural 8-sample debouncer on enc_a
    int   db_cnt = 0, db_rises = 0;
    logic db_last = 1'b0, db_val = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick();
        logic [7:0] lp;
        if (reset) begin
            steps = 0; hk = -1; ml = 8'hA5; m_out = 2'b00;
        end else begin
            lp = ml;
            ml = {ml[6:0], ^(ml & 8'hB8)};
            if (hk < 0) begin
                if (step_valid) begin
                    m_old = tbl[steps & 3];
                    steps += step_dir ? 1 : -1;
                    m_new = tbl[steps & 3];
                    m_bl  = bounce_en;
                    hk    = 0;
                    m_out = (m_bl && B > 0 && !lp[0]) ? m_old : m_new;
                end
            end else if (hk == P - 1) begin
                hk = -1; m_out = m_new;
            end else begin
                hk++;
                m_out = (m_bl && hk < B && !lp[0]) ? m_old : m_new;
            end
        end
        @(posedge clk); #1;
        chk("enc_ab",   {6'd0, enc_a, enc_b}, {6'd0, m_out});
        chk("position", position, 8'(steps));
        chk("busy",     {7'd0, busy}, {7'd0, hk >= 0});
        chk("ready",    {7'd0, step_ready}, {7'd0, hk < 0});
        if (enc_a === db_last) db_cnt++; else db_cnt = 0;
        db_last = enc_a;
        if (db_cnt >= 7 && db_val !== enc_a) begin
            if (enc_a) db_rises++;
            db_val = enc_a;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; step_valid = 1'b0; step_dir = 1'b0; bounce_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; step_valid = 1'b0; step_dir = 1'b0; bounce_en = 1'b0;

        // Reset state
        do_reset();
        chk("rst_lfsr", dut.lfsr, 8'hA5);

        // Four cw steps, valid held high, clean
        step_valid = 1'b1; step_dir = 1'b1;
        repeat (4 * (P + 1)) tick();
        step_valid = 1'b0;
        tick();
        chk("cw4_pos", position, 8'd4);
        chk("cw4_ab", {6'd0, enc_a, enc_b}, 8'd0);

        // ccw steps from reset
        do_reset();
        step_valid = 1'b1; step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        repeat (P) tick();
        chk("ccw1_pos", position, 8'hFF);
        chk("ccw1_ab", {6'd0, enc_a, enc_b}, 8'b01);
        step_valid = 1'b1;
        repeat (3 * (P + 1)) tick();
        step_valid = 1'b0;
        tick();
        chk("ccw4_pos", position, 8'hFC);

        // Bounced cw step through the debouncer
        do_reset();
        db_cnt = 0; db_rises = 0; db_last = 1'b0; db_val = 1'b0;
        step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b1;
        tick();
        step_valid = 1'b0; bounce_en = 1'b0;
        for (int k = 1; k < P; k++) begin
            tick();
            chk("bnc_b", {7'd0, enc_b}, 8'd0);
            if (k >= B) chk("bnc_a_clean", {7'd0, enc_a}, 8'd1);
        end
        repeat (12) tick();
        chk("deb_rises", db_rises[7:0], 8'd1);

        // Requests during HOLD are ignored; direction sampled only in IDLE
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        for (int k = 0; k < P; k++) begin
            step_dir = ~step_dir;
            tick();
        end
        step_dir = 1'b0;
        tick();
        step_valid = 1'b0;
        chk("hold_ign_pos", position, 8'd0);
        repeat (P) tick();

        // Reset in HOLD cycle 5
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_lfsr", dut.lfsr, 8'hA5);
        chk("midrst_pos", position, 8'd0);
        repeat (3) tick();

        // 260 consecutive cw steps with wrap
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1;
        repeat (260 * (P + 1)) tick();
        step_valid = 1'b0;
        tick();
        chk("wrap_pos", position, 8'h04);
        chk("wrap_ab", {6'd0, enc_a, enc_b}, 8'd0);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step_valid = 1'($urandom_range(0, 1));
            step_dir   = 1'($urandom_range(0, 1));
            bounce_en  = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; step_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
